// File: rtl/gpu_l1_cache_if.sv
// Upstream load port, downstream fill port and flush handshake of the GPU L1 cache.
interface gpu_l1_cache_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned LINE_W = 256
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic [LINE_W-1:0] resp_data;
  logic              resp_hit;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_resp_valid;
  logic [LINE_W-1:0] mem_resp_data;
  logic              flush;
  logic              flush_done;

  // Cache side
  modport slave (
    input  req_valid, req_addr, mem_req_ready, mem_resp_valid, mem_resp_data, flush,
    output req_ready, resp_valid, resp_data, resp_hit, mem_req_valid, mem_req_addr, flush_done
  );

  // Shader-core / memory side
  modport master (
    output req_valid, req_addr, mem_req_ready, mem_resp_valid, mem_resp_data, flush,
    input  req_ready, resp_valid, resp_data, resp_hit, mem_req_valid, mem_req_addr, flush_done
  );
endinterface

// File: rtl/gpu_l1_cache.sv
// Blocking, read-only, set-associative L1 cache returning one full line per request.
// Misses fetch the line downstream and fill the victim way (lowest invalid way,
// otherwise the per-set round-robin pointer).
module gpu_l1_cache #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned SETS   = 32,
  parameter int unsigned WAYS   = 4
) (
  input logic           clk,
  input logic           rst_n,
  gpu_l1_cache_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = $clog2(WAYS);
  localparam int unsigned TAG_W = ADDR_W - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_MISS_WAIT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0]            r_addr;
  logic [SETS-1:0][WAYS-1:0]    r_valid;
  logic [SETS-1:0][WAY_W-1:0]   r_victim;
  logic [TAG_W-1:0]             r_tag  [SETS][WAYS];
  logic [LINE_W-1:0]            r_data [SETS][WAYS];

  logic                         r_resp_valid;
  logic [LINE_W-1:0]            r_resp_data;
  logic                         r_resp_hit;
  logic                         r_mem_req_valid;
  logic [ADDR_W-1:0]            r_mem_req_addr;
  logic                         r_flush_done;

  logic [IDX_W-1:0]             w_idx;
  logic [TAG_W-1:0]             w_tag;
  logic                         w_hit;
  logic [WAY_W-1:0]             w_hit_way;
  logic                         w_all_valid;
  logic [WAY_W-1:0]             w_free_way;
  logic [WAY_W-1:0]             w_victim;
  logic                         w_req_ready;
  logic                         w_accept;
  logic                         w_fill;
  logic                         w_flush_clr;
  logic                         w_resp_valid_nxt;
  logic [LINE_W-1:0]            w_resp_data_nxt;
  logic                         w_resp_hit_nxt;
  logic                         w_mem_req_valid_nxt;
  logic [ADDR_W-1:0]            w_mem_req_addr_nxt;
  logic                         w_flush_done_nxt;

  assign w_idx       = r_addr[IDX_W-1:0];
  assign w_tag       = r_addr[ADDR_W-1:IDX_W];
  assign w_req_ready = rst_n && (r_state == S_IDLE) && !bus.flush;

  // Tag compare across the valid ways of the addressed set
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int i = 0; i < int'(WAYS); i++) begin
      if (r_valid[w_idx][i] && (r_tag[w_idx][i] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(i);
      end
    end
  end

  // Victim choice: lowest invalid way, else the set's round-robin pointer
  always_comb begin
    w_all_valid = &r_valid[w_idx];
    w_free_way  = '0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (!r_valid[w_idx][i]) begin
        w_free_way = WAY_W'(i);
      end
    end
    w_victim = w_all_valid ? r_victim[w_idx] : w_free_way;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next values of the registered outputs
  always_comb begin
    w_state_nxt         = r_state;
    w_accept            = 1'b0;
    w_fill              = 1'b0;
    w_flush_clr         = 1'b0;
    w_resp_valid_nxt    = 1'b0;
    w_resp_data_nxt     = r_resp_data;
    w_resp_hit_nxt      = r_resp_hit;
    w_mem_req_valid_nxt = 1'b0;
    w_mem_req_addr_nxt  = r_mem_req_addr;
    w_flush_done_nxt    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.flush) begin
          w_flush_clr      = 1'b1;
          w_flush_done_nxt = 1'b1;
        end else if (bus.req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (w_hit) begin
          w_resp_valid_nxt = 1'b1;
          w_resp_hit_nxt   = 1'b1;
          w_resp_data_nxt  = r_data[w_idx][w_hit_way];
          w_state_nxt      = S_IDLE;
        end else begin
          w_mem_req_valid_nxt = 1'b1;
          w_mem_req_addr_nxt  = r_addr;
          w_state_nxt         = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        if (bus.mem_req_ready) begin
          w_state_nxt = S_MISS_WAIT;
        end else begin
          w_mem_req_valid_nxt = 1'b1;
        end
      end
      S_MISS_WAIT: begin
        if (bus.mem_resp_valid) begin
          w_fill           = 1'b1;
          w_resp_valid_nxt = 1'b1;
          w_resp_hit_nxt   = 1'b0;
          w_resp_data_nxt  = bus.mem_resp_data;
          w_state_nxt      = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs and captured request address
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr          <= '0;
      r_resp_valid    <= 1'b0;
      r_resp_data     <= '0;
      r_resp_hit      <= 1'b0;
      r_mem_req_valid <= 1'b0;
      r_mem_req_addr  <= '0;
      r_flush_done    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr <= bus.req_addr;
      end
      r_resp_valid    <= w_resp_valid_nxt;
      r_resp_data     <= w_resp_data_nxt;
      r_resp_hit      <= w_resp_hit_nxt;
      r_mem_req_valid <= w_mem_req_valid_nxt;
      r_mem_req_addr  <= w_mem_req_addr_nxt;
      r_flush_done    <= w_flush_done_nxt;
    end
  end

  // Valid bits and victim pointers; pointer advances only when it picked the victim
  always_ff @(posedge clk) begin
    if (!rst_n || w_flush_clr) begin
      r_valid  <= '0;
      r_victim <= '0;
    end else if (w_fill) begin
      r_valid[w_idx][w_victim] <= 1'b1;
      if (w_all_valid) begin
        r_victim[w_idx] <= r_victim[w_idx] + WAY_W'(1);
      end
    end
  end

  // Tag and line storage written on fill; contents are qualified by the valid bits
  always_ff @(posedge clk) begin
    if (rst_n && w_fill) begin
      r_tag[w_idx][w_victim]  <= w_tag;
      r_data[w_idx][w_victim] <= bus.mem_resp_data;
    end
  end

  assign bus.req_ready     = w_req_ready;
  assign bus.resp_valid    = r_resp_valid;
  assign bus.resp_data     = r_resp_data;
  assign bus.resp_hit      = r_resp_hit;
  assign bus.mem_req_valid = r_mem_req_valid;
  assign bus.mem_req_addr  = r_mem_req_addr;
  assign bus.flush_done    = r_flush_done;
endmodule
